// File: rtl/intra16_mb_scheduler.sv
// Raster-order macroblock sequencer for the intra-16 mode picker.
// Owns the top reconstruction line buffer plus left/top-left context and launches one pick per MB.
module intra16_mb_scheduler #(
    parameter int MAX_MB_W   = 64,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_start,
    input  logic [9:0]                         mb_w,
    input  logic [9:0]                         mb_h,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] src_data,
    output logic                               pick_start,
    output logic                               pick_clear,
    output logic [9:0]                         pick_x,
    output logic [9:0]                         pick_y,
    output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] pick_ysrc,
    output logic [7:0]                         pick_top_left,
    output logic [8*BLOCK_SIZE-1:0]            pick_top,
    output logic [8*BLOCK_SIZE-1:0]            pick_left,
    input  logic                               pick_done,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] pick_out,
    input  logic [1:0]                         pick_mode,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [9:0]                         res_x,
    output logic [9:0]                         res_y,
    output logic [1:0]                         res_mode,
    output logic                               frame_done,
    output logic                               busy
);
    localparam int         LINE_W = 8 * BLOCK_SIZE;
    localparam int         BLK_W  = LINE_W * BLOCK_SIZE;
    localparam int         AW     = (MAX_MB_W > 1) ? $clog2(MAX_MB_W) : 1;
    localparam logic [9:0] MAX_W  = 10'(MAX_MB_W);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_LOAD   = 4'd3;
    localparam logic [3:0] S_ISSUE  = 4'd4;
    localparam logic [3:0] S_BUSY   = 4'd5;
    localparam logic [3:0] S_UPDATE = 4'd6;
    localparam logic [3:0] S_EMIT   = 4'd7;
    localparam logic [3:0] S_FDONE  = 4'd8;

    logic [3:0]        r_state;
    logic [9:0]        r_w, r_h, r_x, r_y;
    logic [BLK_W-1:0]  r_src;
    logic [LINE_W-1:0] r_top, r_left_ctx, r_left;
    logic [7:0]        r_tl, r_tl_save;
    logic [LINE_W-1:0] r_mem [MAX_MB_W];
    logic [LINE_W-1:0] r_rd_data;
    logic [9:0]        r_res_x, r_res_y;
    logic [1:0]        r_res_mode;

    logic              w_last_col, w_last_row;
    logic [LINE_W-1:0] w_recon_bottom, w_recon_right;
    logic              w_unused;

    assign w_last_col     = (r_x == r_w - 10'd1);
    assign w_last_row     = (r_y == r_h - 10'd1);
    assign w_recon_bottom = pick_out[BLK_W-1 -: LINE_W];
    // Only the bottom row and right column of the reconstruction feed later neighbours.
    assign w_unused       = ^pick_out;

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_recon_right = '0;
        for (int r = 0; r < BLOCK_SIZE; r++)
            w_recon_right[8*r +: 8] = pick_out[8*(BLOCK_SIZE*r + BLOCK_SIZE-1) +: 8];
    end

    // NOTE: the line buffer has no reset; every entry is written in a row before the next row reads it.
    always_ff @(posedge clk) begin
        if (r_state == S_UPDATE)
            r_mem[r_x[AW-1:0]] <= w_recon_bottom;
        r_rd_data <= r_mem[r_x[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_h        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_src      <= '0;
            r_top      <= '0;
            r_left_ctx <= '0;
            r_left     <= '0;
            r_tl       <= '0;
            r_tl_save  <= '0;
            r_res_x    <= '0;
            r_res_y    <= '0;
            r_res_mode <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (frame_start) begin
                    r_w     <= (mb_w > MAX_W) ? MAX_W : mb_w;
                    r_h     <= mb_h;
                    r_state <= S_INIT;
                end
                S_INIT: begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_state <= (r_w == 10'd0 || r_h == 10'd0) ? S_FDONE : S_FETCH;
                end
                S_FETCH: if (src_valid) begin
                    r_src   <= src_data;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_top      <= (r_y == 10'd0) ? {BLOCK_SIZE{8'h7F}} : r_rd_data;
                    r_left_ctx <= (r_x == 10'd0) ? {BLOCK_SIZE{8'h81}} : r_left;
                    // NOTE: non-blocking, so r_tl picks up the byte saved by the previous MB, not this one.
                    r_tl       <= (r_y == 10'd0) ? 8'h7F : (r_x == 10'd0) ? 8'h81 : r_tl_save;
                    r_tl_save  <= r_rd_data[8*(BLOCK_SIZE-1) +: 8];
                    r_state    <= S_ISSUE;
                end
                S_ISSUE: r_state <= S_BUSY;
                S_BUSY: if (pick_done) r_state <= S_UPDATE;
                S_UPDATE: begin
                    r_left     <= w_recon_right;
                    r_res_x    <= r_x;
                    r_res_y    <= r_y;
                    r_res_mode <= pick_mode;
                    r_state    <= S_EMIT;
                end
                S_EMIT: if (res_ready) begin
                    if (w_last_col) begin
                        r_x <= '0;
                        r_y <= r_y + 10'd1;
                    end else begin
                        r_x <= r_x + 10'd1;
                    end
                    r_state <= (w_last_col && w_last_row) ? S_FDONE : S_FETCH;
                end
                S_FDONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign src_ready     = (r_state == S_FETCH);
    assign pick_start    = (r_state == S_ISSUE);
    assign pick_clear    = (r_state == S_INIT);
    assign res_valid     = (r_state == S_EMIT);
    assign frame_done    = (r_state == S_FDONE);
    assign busy          = (r_state != S_IDLE) && (r_state != S_FDONE);
    assign pick_x        = r_x;
    assign pick_y        = r_y;
    assign pick_ysrc     = r_src;
    assign pick_top      = r_top;
    assign pick_left     = r_left_ctx;
    assign pick_top_left = r_tl;
    assign res_x         = r_res_x;
    assign res_y         = r_res_y;
    assign res_mode      = r_res_mode;
endmodule

// File: tb/tb_intra16_mb_scheduler.sv
// Scoreboard bench for intra16_mb_scheduler: an image-level model predicts pick contexts and results.
module tb_intra16_mb_scheduler;
    localparam int MAX_W = 8;

    typedef struct packed {
        logic [9:0]    x;
        logic [9:0]    y;
        logic [2047:0] src;
        logic [127:0]  top;
        logic [127:0]  left;
        logic [7:0]    tl;
    } pick_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] mode;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    mb_w = '0, mb_h = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [2047:0] src_data = '0;
    logic          pick_start, pick_clear;
    logic [9:0]    pick_x, pick_y;
    logic [2047:0] pick_ysrc;
    logic [7:0]    pick_top_left;
    logic [127:0]  pick_top, pick_left;
    logic          pick_done = 1'b0;
    logic [2047:0] pick_out = '0;
    logic [1:0]    pick_mode = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [9:0]    res_x, res_y;
    logic [1:0]    res_mode;
    logic          frame_done, busy;

    intra16_mb_scheduler #(.MAX_MB_W(MAX_W), .BLOCK_SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mb_w(mb_w), .mb_h(mb_h),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .pick_start(pick_start), .pick_clear(pick_clear), .pick_x(pick_x), .pick_y(pick_y),
        .pick_ysrc(pick_ysrc), .pick_top_left(pick_top_left), .pick_top(pick_top),
        .pick_left(pick_left), .pick_done(pick_done), .pick_out(pick_out), .pick_mode(pick_mode),
        .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .res_mode(res_mode), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0, n_bad = 0;
    pick_t         q_pick[$];
    res_t          q_res[$];
    logic [2047:0] q_out[$];
    logic [1:0]    q_mode[$];
    pick_t         cur_pick;
    int            clr_cnt = 0, fd_cnt = 0, start_cnt = 0, sr_cnt = 0, stall_seen = 0;
    int            rr_mode = 0, stall_left = 0;
    bit            pick_hold = 1'b0;
    bit            prev_stall = 1'b0;
    res_t          prev_res;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    function automatic logic [2047:0] rand_blk();
        logic [2047:0] b;
        for (int j = 0; j < 64; j++) b[32*j +: 32] = $urandom;
        return b;
    endfunction

    // Monitor: compares pick launches and results against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (pick_clear) clr_cnt++;
            if (src_ready) sr_cnt++;
            if (frame_done) begin
                fd_cnt++;
                check("busy_at_frame_done", busy, 0);
            end
            if (pick_start) begin
                start_cnt++;
                if (q_pick.size() == 0) begin
                    fail("unexpected_pick_start");
                end else begin
                    pick_t e;
                    int k;
                    e = q_pick.pop_front();
                    cur_pick = e;
                    check("pick_xy", {pick_x, pick_y}, {e.x, e.y});
                    check("pick_top", pick_top, e.top);
                    check("pick_left", pick_left, e.left);
                    check("pick_top_left", pick_top_left, e.tl);
                    k = 0;
                    for (int j = 0; j < 16; j++)
                        if (pick_ysrc[128*j +: 128] !== e.src[128*j +: 128]) begin k = j; break; end
                    check($sformatf("pick_ysrc_chunk%0d", k), pick_ysrc[128*k +: 128], e.src[128*k +: 128]);
                end
            end
            if (prev_stall) begin
                check("stall_res_valid", res_valid, 1);
                check("stall_res_fields", {res_x, res_y, res_mode}, prev_res);
                check("stall_src_ready", src_ready, 0);
                check("stall_pick_start", pick_start, 0);
            end
            if (res_valid && res_ready) begin
                if (q_res.size() == 0) fail("unexpected_result");
                else check("result", {res_x, res_y, res_mode}, q_res.pop_front());
            end
            prev_stall = res_valid && !res_ready;
            if (prev_stall) stall_seen++;
            prev_res = {res_x, res_y, res_mode};
        end
    end

    // Picker model: answers each launch after a random latency with the preplanned reconstruction.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (rst_n && pick_start && !pick_hold) begin
                if (q_out.size() == 0) begin
                    fail("picker_response_queue");
                end else begin
                    lat = $urandom_range(0, 4);
                    @(posedge clk);
                    repeat (lat) @(posedge clk);
                    #1;
                    check("stable_xy", {pick_x, pick_y}, {cur_pick.x, cur_pick.y});
                    check("stable_top", pick_top, cur_pick.top);
                    check("stable_left", pick_left, cur_pick.left);
                    pick_out  = q_out.pop_front();
                    pick_mode = q_mode.pop_front();
                    pick_done = 1'b1;
                    @(posedge clk);
                    #1 pick_done = 1'b0;
                end
            end
        end
    end

    // Result backpressure: always ready, random, or a single 10-cycle stall.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (res_valid && stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic start_frame(input int w, input int h);
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        mb_w = 10'(w);
        mb_h = 10'(h);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        mb_w = 10'($urandom);
        mb_h = 10'($urandom);
        @(negedge clk);
        check("pick_clear_pulse", pick_clear, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed_src(input logic [2047:0] s, output bit ok);
        int b;
        src_valid = 1'b1;
        src_data  = s;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!src_ready && b < 500);
        ok = src_ready;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        src_data  = rand_blk();
    endtask

    task automatic run_frame(input int w, input int h, input bit pattern, input bit glitch);
        int            ew, n, b;
        bit            ok;
        logic [2047:0] srcs[$];
        logic [2047:0] outs[$];
        pick_t         p;
        res_t          r;
        ew = (w > MAX_W) ? MAX_W : w;
        n  = (ew == 0 || h == 0) ? 0 : ew * h;
        for (int i = 0; i < n; i++) begin
            logic [2047:0] o;
            int xx, yy;
            xx = i % ew;
            yy = i / ew;
            srcs.push_back(rand_blk());
            if (pattern) begin
                for (int rr = 0; rr < 16; rr++)
                    for (int c = 0; c < 16; c++)
                        o[8*(16*rr+c) +: 8] = {xx[0], yy[0], rr[1:0], c[3:0]};
            end else begin
                o = rand_blk();
            end
            outs.push_back(o);
        end
        // Context comes straight from the reconstructed image of neighbouring macroblocks.
        for (int i = 0; i < n; i++) begin
            int xx, yy;
            xx = i % ew;
            yy = i / ew;
            p.x = 10'(xx);
            p.y = 10'(yy);
            p.src = srcs[i];
            for (int c = 0; c < 16; c++) begin
                if (yy == 0) p.top[8*c +: 8] = 8'h7F;
                else p.top[8*c +: 8] = outs[i-ew][8*(240+c) +: 8];
                if (xx == 0) p.left[8*c +: 8] = 8'h81;
                else p.left[8*c +: 8] = outs[i-1][8*(16*c+15) +: 8];
            end
            if (yy == 0) p.tl = 8'h7F;
            else if (xx == 0) p.tl = 8'h81;
            else p.tl = outs[i-ew-1][8*255 +: 8];
            r.x = p.x;
            r.y = p.y;
            r.mode = 2'($urandom_range(0, 3));
            q_pick.push_back(p);
            q_res.push_back(r);
            q_out.push_back(outs[i]);
            q_mode.push_back(r.mode);
        end
        clr_cnt = 0; fd_cnt = 0; start_cnt = 0; sr_cnt = 0;
        start_frame(w, h);
        if (n == 0) begin
            @(negedge clk);
            check("empty_frame_done_latency", frame_done, 1);
        end else begin
            for (int i = 0; i < n; i++) begin
                @(posedge clk);
                #1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (glitch && i == 1) begin
                    frame_start = 1'b1;
                    mb_w = 10'd1;
                    mb_h = 10'd1;
                    @(posedge clk);
                    #1 frame_start = 1'b0;
                end
                feed_src(srcs[i], ok);
                if (!ok) begin
                    fail("src_ready_timeout");
                    return;
                end
            end
            b = 0;
            while (!frame_done && b < 2000) begin
                @(negedge clk);
                b++;
            end
            if (!frame_done) begin
                fail("frame_done_timeout");
                return;
            end
        end
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 0);
        check("busy_idle", busy, 0);
        check("frame_done_count", fd_cnt, 1);
        check("pick_clear_count", clr_cnt, 1);
        check("pick_start_count", start_cnt, n);
        check("picks_outstanding", q_pick.size(), 0);
        check("results_outstanding", q_res.size(), 0);
        if (n == 0) check("src_ready_cycles", sr_cnt, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {src_ready, pick_start, pick_clear, res_valid, frame_done, busy}, 0);
        check({tag, "_res"}, {res_x, res_y, res_mode}, 0);
        check({tag, "_pos"}, {pick_x, pick_y, pick_top_left}, 0);
        check({tag, "_top"}, pick_top, 0);
        check({tag, "_left"}, pick_left, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pick_t p;
        bit    ok;
        int    b;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        run_frame(1, 1, 1'b0, 1'b0);
        run_frame(2, 2, 1'b1, 1'b0);
        rr_mode = 1;
        run_frame(3, 2, 1'b0, 1'b1);

        rr_mode = 2;
        stall_left = 10;
        stall_seen = 0;
        run_frame(2, 1, 1'b0, 1'b0);
        check("stall_cycles", stall_seen, 10);

        rr_mode = 0;
        run_frame(0, 3, 1'b0, 1'b0);
        run_frame(4, 0, 1'b0, 1'b0);
        run_frame(11, 2, 1'b0, 1'b0);

        rr_mode = 1;
        for (int f = 0; f < 4; f++)
            run_frame($urandom_range(1, 6), $urandom_range(1, 3), 1'b0, 1'b0);

        // Abort a frame while the picker is working, then check a clean restart.
        rr_mode = 0;
        pick_hold = 1'b1;
        p.x = '0;
        p.y = '0;
        p.src = rand_blk();
        p.top = {16{8'h7F}};
        p.left = {16{8'h81}};
        p.tl = 8'h7F;
        q_pick.push_back(p);
        start_frame(2, 2);
        @(posedge clk);
        #1 feed_src(p.src, ok);
        if (!ok) fail("abort_src_ready_timeout");
        b = 0;
        while (!pick_start && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!pick_start) fail("abort_pick_start_timeout");
        repeat (3) @(negedge clk);
        check("busy_wait_no_result", {res_valid, src_ready, busy}, 3'b001);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        pick_hold = 1'b0;
        check("abort_picks_outstanding", q_pick.size(), 0);
        run_frame(1, 1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/intra16_mb_scheduler.md
Name: intra16_mb_scheduler

Overview:
- Frame-level sequencer for the intra-16 mode picker.
- Walks macroblocks in raster order and accepts each 16x16 source block over a valid/ready handshake.
- Builds the top, left and top-left prediction context from its own reconstruction line buffer, launches one pick per macroblock, then writes the reconstructed edges back for later neighbours.
- Sits between the source-block fetch path and the picker; hands each finished macroblock's coordinates and mode downstream.

Parameters:
- MAX_MB_W, 64, maximum macroblocks per row; sets top line-buffer depth.
- BLOCK_SIZE, 16, macroblock edge in pixels; only 16 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; samples mb_w/mb_h and begins a frame
- mb_w  in  10  macroblocks per row
- mb_h  in  10  macroblock rows
- src_valid  in  1  source block available
- src_ready  out  1  scheduler accepts source block
- src_data  in  2048  source pixels; byte 16r+c at bits [8*(16r+c)+:8]
- pick_start  out  1  one-cycle launch pulse to the picker
- pick_clear  out  1  one-cycle pulse at frame begin (clears max_edge)
- pick_x  out  10  macroblock column
- pick_y  out  10  macroblock row
- pick_ysrc  out  2048  held source block
- pick_top_left  out  8  top-left pixel
- pick_top  out  128  top row; byte c at [8c+:8]
- pick_left  out  128  left column; byte r at [8r+:8]
- pick_done  in  1  picker finished
- pick_out  in  2048  reconstructed block, same layout as src_data
- pick_mode  in  2  chosen mode (mode_i16[1:0])
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_x  out  10  column of result
- res_y  out  10  row of result
- res_mode  out  2  mode of result
- frame_done  out  1  one-cycle pulse after last result accepted
- busy  out  1  high from frame_start accept until frame_done

Behaviour:
- Reset: FSM to IDLE; x, y, width/height registers and all context registers cleared. All outputs 0.
- Line buffer: MAX_MB_W x 128-bit top memory, one read and one write port, 1-cycle registered read. Not reset; each entry is written before it is read within a frame.
- FSM states: IDLE, INIT, FETCH, LOAD, ISSUE, BUSY, UPDATE, EMIT, FDONE.
- IDLE: on frame_start, latch mb_w and mb_h, saturating mb_w to MAX_MB_W. Go to INIT. frame_start in any other state is ignored.
- INIT: pick_clear=1 for one cycle; x=y=0.
  - If either latched dimension is 0, go to FDONE; otherwise go to FETCH.
- FETCH: src_ready=1. Top memory read address = x.
  - On src_valid&src_ready, capture src_data and go to LOAD.
- LOAD: build context.
  - pick_top: if y==0, all bytes 0x7F; else read data.
  - pick_left: if x==0, all bytes 0x81; else left register.
  - pick_top_left: if y==0, 0x7F; else if x==0, 0x81; else tl_save.
  - Capture tl_save <= read data byte 15. This holds the un-overwritten top[x] byte 15 for MB x+1.
- ISSUE: pick_start=1 for exactly one cycle, i.e. two cycles after the source accept cycle.
  - pick_x, pick_y, pick_ysrc and all context outputs are stable from ISSUE until leaving BUSY.
- BUSY: wait for pick_done. pick_done in any other state is ignored.
- UPDATE, one cycle:
  - top[x] <= pick_out bytes 240..255.
  - left register <= pick_out bytes 16r+15, r=0..15.
  - res_x/res_y <= x/y; res_mode <= pick_mode.
- EMIT: res_valid=1 held until res_ready; outputs stable while stalled.
  - On handshake, if x==mb_w-1: x=0, y++ and the left register is don't-care (next MB has x==0); else x++.
  - If the last macroblock was just emitted, go to FDONE; else go to FETCH.
  - res_ready asserted in the same cycle res_valid first rises completes the transfer.
- FDONE: frame_done=1 for one cycle, then IDLE. busy falls in the same cycle.
- Only one macroblock is in flight; src_ready is low outside FETCH.
- Reset asserted mid-frame aborts immediately. No result or frame_done is emitted, and the next frame restarts cleanly from INIT.
- Coordinate counters are 10-bit; no wrap is possible within MAX_MB_W/mb_h limits.

Test Plan:
- 1x1 frame → one pick_clear pulse; at pick_start: x=0, y=0, top all 0x7F, left all 0x81, top_left 0x7F. Return done with mode 2 → res (0,0,2), then frame_done, busy low.
- 2x2 frame, pick_out byte(16r+c) = {x,y,r[1:0],c[3:0]} pattern → MB(1,1):
  - top = MB(1,0) bytes 240..255;
  - left = MB(0,1) column 15;
  - top_left = MB(0,0) byte 255;
  - MB(0,1) has left 0x81 and top_left 0x81.
- Row wrap with mb_w=3, mb_h=2 → result order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); exactly 6 pick_start pulses.
- res_ready low for 10 cycles at MB(0,0) → res_valid and res fields held, src_ready low, no pick_start; release → next FETCH.
- mb_w=0 or mb_h=0 → pick_clear then frame_done 2 cycles after frame_start; no pick_start, src_ready never high.
- rst_n asserted during BUSY, then new 1x1 frame → no stale res_valid; context again 0x7F/0x81.
